// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between execute and writeback
// Holds one bundle, waits for load data, extracts/extends it and forwards to writeback.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_to_MEM_valid,
  output logic        MEM_allow_in,
  input  logic [73:0] to_MEM_data,
  input  logic        WB_allow_in,
  output logic        MEM_to_WB_valid,
  output logic [69:0] to_WB_data,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [4:0]  MEM_dest,
  output logic        MEM_fwd_valid,
  output logic [31:0] MEM_fwd_value
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_BUSY = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [73:0] bundle_q, bundle_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        rbuf_valid_q, rbuf_valid_d;

  logic [31:0] pc;
  logic [31:0] alu_result;
  logic        res_from_mem;
  logic [2:0]  load_op;
  logic [4:0]  dest;
  logic        gr_we;

  logic        data_ok_in_wait;
  logic        mem_ready_go;
  logic        departing;
  logic        accepting;

  logic [31:0] raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign pc           = bundle_q[73:42];
  assign alu_result   = bundle_q[41:10];
  assign res_from_mem = bundle_q[9];
  assign load_op      = bundle_q[8:6];
  assign dest         = bundle_q[5:1];
  assign gr_we        = bundle_q[0];

  // A response only counts while a load is actually waiting for it; stray
  // responses (e.g. one left outstanding across reset) are dropped.
  always_comb begin
    data_ok_in_wait = data_sram_data_ok & (state_q == S_WAIT);
    mem_ready_go    = ~res_from_mem | data_ok_in_wait | rbuf_valid_q;
    MEM_allow_in    = ~mem_valid_q | (mem_ready_go & WB_allow_in);
    departing       = mem_valid_q & mem_ready_go & WB_allow_in;
    accepting       = MEM_allow_in & EX_to_MEM_valid;
  end

  always_comb begin
    raw = rbuf_valid_q ? rbuf_q : data_sram_rdata;
    case (alu_result[1:0])
      2'd0:    ld_byte = raw[7:0];
      2'd1:    ld_byte = raw[15:8];
      2'd2:    ld_byte = raw[23:16];
      default: ld_byte = raw[31:24];
    endcase
    ld_half = alu_result[1] ? raw[31:16] : raw[15:0];
    case (load_op)
      3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b011:  load_data = {24'd0, ld_byte};
      3'b010:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {16'd0, ld_half};
      default: load_data = raw;
    endcase
    final_result = res_from_mem ? load_data : alu_result;
  end

  always_comb begin
    mem_valid_d  = mem_valid_q;
    bundle_d     = bundle_q;
    rbuf_d       = rbuf_q;
    rbuf_valid_d = rbuf_valid_q;
    state_d      = state_q;

    if (MEM_allow_in) begin
      mem_valid_d = EX_to_MEM_valid;
    end
    if (accepting) begin
      bundle_d = to_MEM_data;
    end

    // Data arriving while writeback is blocked must be parked: the SRAM
    // drives rdata for a single cycle only.
    if (data_ok_in_wait && !WB_allow_in) begin
      rbuf_d       = data_sram_rdata;
      rbuf_valid_d = 1'b1;
    end
    if (departing) begin
      rbuf_valid_d = 1'b0;
    end

    if (MEM_allow_in) begin
      if (EX_to_MEM_valid) begin
        state_d = to_MEM_data[9] ? S_WAIT : S_BUSY;
      end else begin
        state_d = S_IDLE;
      end
    end else if (data_ok_in_wait) begin
      state_d = S_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q  <= 1'b0;
      bundle_q     <= 74'd0;
      rbuf_q       <= 32'd0;
      rbuf_valid_q <= 1'b0;
      state_q      <= S_IDLE;
    end else begin
      mem_valid_q  <= mem_valid_d;
      bundle_q     <= bundle_d;
      rbuf_q       <= rbuf_d;
      rbuf_valid_q <= rbuf_valid_d;
      state_q      <= state_d;
    end
  end

  assign MEM_to_WB_valid = mem_valid_q & mem_ready_go;
  assign to_WB_data      = {pc, final_result, dest, gr_we};
  assign MEM_dest        = dest & {5{mem_valid_q & gr_we}};
  assign MEM_fwd_valid   = mem_valid_q & gr_we & mem_ready_go;
  assign MEM_fwd_value   = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_to_MEM_valid;
  logic        MEM_allow_in;
  logic [73:0] to_MEM_data;
  logic        WB_allow_in;
  logic        MEM_to_WB_valid;
  logic [69:0] to_WB_data;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [4:0]  MEM_dest;
  logic        MEM_fwd_valid;
  logic [31:0] MEM_fwd_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .EX_to_MEM_valid   (EX_to_MEM_valid),
    .MEM_allow_in      (MEM_allow_in),
    .to_MEM_data       (to_MEM_data),
    .WB_allow_in       (WB_allow_in),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .to_WB_data        (to_WB_data),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .MEM_dest          (MEM_dest),
    .MEM_fwd_valid     (MEM_fwd_valid),
    .MEM_fwd_value     (MEM_fwd_value)
  );

  function automatic logic [73:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                     input logic rfm, input logic [2:0] op,
                                     input logic [4:0] dest, input logic we);
    return {pc, alu, rfm, op, dest, we};
  endfunction

  // Load result from the ISA rules, using arithmetic rather than bit slicing.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(raw >> (8 * a));
    h = 16'(raw >> (a[1] ? 16 : 0));
    case (op)
      3'd1:    return b[7] ? 32'(b) - 32'd256 : 32'(b);
      3'd3:    return 32'(b);
      3'd2:    return h[15] ? 32'(h) - 32'h10000 : 32'(h);
      3'd4:    return 32'(h);
      default: return raw;
    endcase
  endfunction

  function automatic logic [69:0] ref_result(input logic [73:0] b, input logic [31:0] raw);
    logic [31:0] fin;
    fin = b[9] ? ref_load(b[8:6], b[11:10], raw) : b[41:10];
    return {b[73:42], fin, b[5:1], b[0]};
  endfunction

  task automatic idle_inputs();
    EX_to_MEM_valid   = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
    WB_allow_in       = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    to_MEM_data = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (MEM_to_WB_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", MEM_to_WB_valid); end
    checks++; if (MEM_dest !== 5'd0) begin errors++; $display("FAIL reset_dest: got %0d want 0", MEM_dest); end
    checks++; if (MEM_fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %0b want 0", MEM_fwd_valid); end
    checks++; if (MEM_allow_in !== 1'b1) begin errors++; $display("FAIL reset_allow: got %0b want 1", MEM_allow_in); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_nonload();
    logic [73:0] b;
    b = mk(32'h1c000000, 32'h12345678, 1'b0, 3'd0, 5'd5, 1'b1);
    @(negedge clk); idle_inputs(); EX_to_MEM_valid = 1'b1; to_MEM_data = b;
    @(negedge clk); EX_to_MEM_valid = 1'b0; #1;
    checks++; if (MEM_to_WB_valid !== 1'b1) begin errors++; $display("FAIL nonload_valid: got %0b want 1", MEM_to_WB_valid); end
    checks++; if (to_WB_data !== {32'h1c000000, 32'h12345678, 5'd5, 1'b1}) begin errors++; $display("FAIL nonload_data: got %h want %h", to_WB_data, {32'h1c000000, 32'h12345678, 5'd5, 1'b1}); end
    checks++; if (MEM_dest !== 5'd5) begin errors++; $display("FAIL nonload_dest: got %0d want 5", MEM_dest); end
    checks++; if (MEM_fwd_valid !== 1'b1) begin errors++; $display("FAIL nonload_fwd: got %0b want 1", MEM_fwd_valid); end
    checks++; if (MEM_fwd_value !== 32'h12345678) begin errors++; $display("FAIL nonload_fwdval: got %h want 12345678", MEM_fwd_value); end
    @(negedge clk); #1;
    checks++; if (MEM_to_WB_valid !== 1'b0) begin errors++; $display("FAIL nonload_drain: got %0b want 0", MEM_to_WB_valid); end
  endtask

  task automatic test_zero_wait_load();
    logic [73:0] b;
    logic [31:0] want;
    for (int i = 0; i < 2; i++) begin
      b = mk(32'(32'h1c000100 + i * 4), 32'h3, 1'b1, (i == 0) ? 3'd1 : 3'd3, 5'd9, 1'b1);
      want = (i == 0) ? 32'hFFFFFF80 : 32'h00000080;
      @(negedge clk); idle_inputs(); EX_to_MEM_valid = 1'b1; to_MEM_data = b;
      @(negedge clk); EX_to_MEM_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF7F01; #1;
      checks++; if (MEM_to_WB_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %0b want 1", i, MEM_to_WB_valid); end
      checks++; if (to_WB_data !== {b[73:42], want, 5'd9, 1'b1}) begin errors++; $display("FAIL zw_data[%0d]: got %h want %h", i, to_WB_data, {b[73:42], want, 5'd9, 1'b1}); end
      checks++; if (MEM_fwd_valid !== 1'b1) begin errors++; $display("FAIL zw_fwd[%0d]: got %0b want 1", i, MEM_fwd_valid); end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_delayed_load();
    logic [73:0] b;
    b = mk(32'h1c000200, 32'h2, 1'b1, 3'd2, 5'd12, 1'b1);
    @(negedge clk); idle_inputs(); EX_to_MEM_valid = 1'b1; to_MEM_data = b;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle_inputs(); #1;
      checks++; if (MEM_allow_in !== 1'b0) begin errors++; $display("FAIL dl_allow[%0d]: got %0b want 0", k, MEM_allow_in); end
      checks++; if (MEM_fwd_valid !== 1'b0) begin errors++; $display("FAIL dl_fwd[%0d]: got %0b want 0", k, MEM_fwd_valid); end
    end
    @(negedge clk); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h9ABC1234; #1;
    checks++; if (MEM_to_WB_valid !== 1'b1) begin errors++; $display("FAIL dl_valid: got %0b want 1", MEM_to_WB_valid); end
    checks++; if (MEM_fwd_value !== 32'hFFFF9ABC) begin errors++; $display("FAIL dl_result: got %h want ffff9abc", MEM_fwd_value); end
    checks++; if (MEM_allow_in !== 1'b1) begin errors++; $display("FAIL dl_allow_end: got %0b want 1", MEM_allow_in); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [73:0] b;
    b = mk(32'h1c000300, 32'h100, 1'b1, 3'd0, 5'd3, 1'b1);
    @(negedge clk); idle_inputs(); EX_to_MEM_valid = 1'b1; to_MEM_data = b;
    @(negedge clk); EX_to_MEM_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF; WB_allow_in = 1'b0; #1;
    checks++; if (MEM_to_WB_valid !== 1'b1) begin errors++; $display("FAIL bp_valid0: got %0b want 1", MEM_to_WB_valid); end
    checks++; if (MEM_allow_in !== 1'b0) begin errors++; $display("FAIL bp_allow0: got %0b want 0", MEM_allow_in); end
    // second response while holding must not disturb the parked data
    @(negedge clk); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11111111; WB_allow_in = 1'b0; #1;
    checks++; if (MEM_fwd_value !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold1: got %h want deadbeef", MEM_fwd_value); end
    checks++; if (MEM_allow_in !== 1'b0) begin errors++; $display("FAIL bp_allow1: got %0b want 0", MEM_allow_in); end
    @(negedge clk); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h22222222; WB_allow_in = 1'b1;
    EX_to_MEM_valid = 1'b1; to_MEM_data = mk(32'h1c000304, 32'h104, 1'b1, 3'd0, 5'd4, 1'b1); #1;
    checks++; if (to_WB_data !== {32'h1c000300, 32'hDEADBEEF, 5'd3, 1'b1}) begin errors++; $display("FAIL bp_release: got %h want %h", to_WB_data, {32'h1c000300, 32'hDEADBEEF, 5'd3, 1'b1}); end
    checks++; if (MEM_allow_in !== 1'b1) begin errors++; $display("FAIL bp_allow2: got %0b want 1", MEM_allow_in); end
    @(negedge clk); idle_inputs(); data_sram_rdata = 32'h33333333; #1;
    checks++; if (MEM_to_WB_valid !== 1'b0) begin errors++; $display("FAIL bp_next_wait: got %0b want 0", MEM_to_WB_valid); end
    @(negedge clk); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5A5A0F0F; #1;
    checks++; if (to_WB_data !== {32'h1c000304, 32'h5A5A0F0F, 5'd4, 1'b1}) begin errors++; $display("FAIL bp_next_data: got %h want %h", to_WB_data, {32'h1c000304, 32'h5A5A0F0F, 5'd4, 1'b1}); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk); idle_inputs(); EX_to_MEM_valid = 1'b1;
    to_MEM_data = mk(32'h1c000400, 32'h200, 1'b1, 3'd0, 5'd6, 1'b1);
    @(negedge clk); idle_inputs(); #1;
    checks++; if (MEM_dest !== 5'd6) begin errors++; $display("FAIL rmw_dest_wait: got %0d want 6", MEM_dest); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEF00D; #1;
    checks++; if (MEM_to_WB_valid !== 1'b0) begin errors++; $display("FAIL rmw_valid: got %0b want 0", MEM_to_WB_valid); end
    checks++; if (MEM_dest !== 5'd0) begin errors++; $display("FAIL rmw_dest: got %0d want 0", MEM_dest); end
    checks++; if (MEM_fwd_valid !== 1'b0) begin errors++; $display("FAIL rmw_fwd: got %0b want 0", MEM_fwd_valid); end
    checks++; if (MEM_allow_in !== 1'b1) begin errors++; $display("FAIL rmw_allow: got %0b want 1", MEM_allow_in); end
    @(negedge clk); idle_inputs(); EX_to_MEM_valid = 1'b1;
    to_MEM_data = mk(32'h1c000404, 32'h201, 1'b1, 3'd3, 5'd8, 1'b1);
    @(negedge clk); idle_inputs(); #1;
    checks++; if (MEM_to_WB_valid !== 1'b0) begin errors++; $display("FAIL rmw_no_stale: got %0b want 0", MEM_to_WB_valid); end
    @(negedge clk); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000AB00; #1;
    checks++; if (MEM_fwd_value !== 32'h000000AB) begin errors++; $display("FAIL rmw_result: got %h want 000000ab", MEM_fwd_value); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [73:0] b, prev;
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      b = mk(32'($urandom), 32'($urandom), 1'b0, 3'($urandom), 5'($urandom), 1'($urandom));
      @(negedge clk); idle_inputs(); EX_to_MEM_valid = 1'b1; to_MEM_data = b; #1;
      checks++; if (MEM_allow_in !== 1'b1) begin errors++; $display("FAIL b2b_allow[%0d]: got %0b want 1", i, MEM_allow_in); end
      if (i > 0) begin
        checks++; if (MEM_to_WB_valid !== 1'b1 || to_WB_data !== ref_result(prev, 32'd0)) begin errors++; $display("FAIL b2b_out[%0d]: got v=%0b %h want v=1 %h", i, MEM_to_WB_valid, to_WB_data, ref_result(prev, 32'd0)); end
      end
      prev = b;
    end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (MEM_to_WB_valid !== 1'b1 || to_WB_data !== ref_result(prev, 32'd0)) begin errors++; $display("FAIL b2b_last: got v=%0b %h want v=1 %h", MEM_to_WB_valid, to_WB_data, ref_result(prev, 32'd0)); end
    @(negedge clk); idle_inputs();
  endtask

  // Model: one slot holding the in-flight instruction, its memory response
  // latency and the result it must produce.
  task automatic test_random();
    bit          occ, delivered, do_ok, ready, exp_allow, wb, ex_v;
    int          lat;
    logic [73:0] cur, nb;
    logic [31:0] ld_data;
    logic [69:0] exp_out;
    logic [4:0]  exp_dest;
    occ = 0; delivered = 0; lat = 0; cur = '0; ld_data = '0; exp_out = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      do_ok = occ && cur[9] && !delivered && (lat == 0);
      wb    = ($urandom_range(0, 3) != 0);
      ex_v  = ($urandom_range(0, 2) != 0);
      nb    = mk(32'($urandom), 32'($urandom), 1'($urandom), 3'($urandom), 5'($urandom), 1'($urandom));
      data_sram_data_ok = do_ok;
      data_sram_rdata   = do_ok ? ld_data : 32'($urandom);
      WB_allow_in       = wb;
      EX_to_MEM_valid   = ex_v;
      to_MEM_data       = nb;
      #1;
      ready     = occ && (!cur[9] || delivered || do_ok);
      exp_allow = !occ || (ready && wb);
      exp_dest  = (occ && cur[0]) ? cur[5:1] : 5'd0;
      checks++; if (MEM_allow_in !== exp_allow) begin errors++; $display("FAIL rnd_allow c=%0d: got %0b want %0b", c, MEM_allow_in, exp_allow); end
      checks++; if (MEM_to_WB_valid !== ready) begin errors++; $display("FAIL rnd_valid c=%0d: got %0b want %0b", c, MEM_to_WB_valid, ready); end
      checks++; if (MEM_fwd_valid !== (ready && cur[0])) begin errors++; $display("FAIL rnd_fwd c=%0d: got %0b want %0b", c, MEM_fwd_valid, ready && cur[0]); end
      checks++; if (MEM_dest !== exp_dest) begin errors++; $display("FAIL rnd_dest c=%0d: got %0d want %0d", c, MEM_dest, exp_dest); end
      if (ready) begin
        checks++; if (to_WB_data !== exp_out) begin errors++; $display("FAIL rnd_data c=%0d: got %h want %h", c, to_WB_data, exp_out); end
      end
      if (do_ok) delivered = 1;
      else if (occ && cur[9] && !delivered) lat--;
      if (ready && wb) occ = 0;
      if (exp_allow && ex_v) begin
        occ       = 1;
        cur       = nb;
        delivered = 0;
        lat       = $urandom_range(0, 3);
        ld_data   = $urandom;
        exp_out   = ref_result(nb, ld_data);
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_nonload();
    test_zero_wait_load();
    test_delayed_load();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
